// File: rtl/tetris_game_ctrl.sv
// Game sequencer for the falling-piece engine: spawns pieces, paces gravity, commits
// landed pieces, scans/clears full rows one at a time and keeps score, lines and level.
module tetris_game_ctrl #(
    parameter int ROWS          = 12,
    parameter int GRAV_W        = 24,
    parameter int GRAV_BASE     = 10_000_000,
    parameter int GRAV_STEP     = 1_000_000,
    parameter int GRAV_MIN      = 2_000_000,
    parameter int LINES_PER_LVL = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Ack,
    input  logic            bottom_flag,
    input  logic            top_flag,
    input  logic [ROWS-1:0] row_full,
    output logic            gen_flag,
    output logic            drop_tick,
    output logic            commit,
    output logic            clear_row,
    output logic [3:0]      clear_idx,
    output logic [15:0]     score,
    output logic [7:0]      lines,
    output logic [3:0]      level,
    output logic            game_over,
    output logic [7:0]      state
);

    typedef enum logic [7:0] {
        IDLE   = 8'h01,
        GEN    = 8'h02,
        PLAY   = 8'h04,
        COMMIT = 8'h08,
        SCAN   = 8'h10,
        CLEAR  = 8'h20,
        SCORE  = 8'h40,
        OVER   = 8'h80
    } state_t;

    localparam logic [GRAV_W-1:0] BASE_W   = GRAV_W'(GRAV_BASE);
    localparam logic [GRAV_W-1:0] STEP_W   = GRAV_W'(GRAV_STEP);
    localparam logic [GRAV_W-1:0] MIN_W    = GRAV_W'(GRAV_MIN);
    localparam logic [3:0]        LAST_ROW = 4'(ROWS - 1);
    localparam logic [7:0]        LPL_W    = 8'(LINES_PER_LVL);

    state_t            state_q, state_d;
    logic              gen_flag_q, gen_flag_d;
    logic              drop_tick_q, drop_tick_d;
    logic              commit_q, commit_d;
    logic              clear_row_q, clear_row_d;
    logic              game_over_q, game_over_d;
    logic [3:0]        clear_idx_q, clear_idx_d;
    logic [15:0]       score_q, score_d;
    logic [7:0]        lines_q, lines_d;
    logic [3:0]        level_q, level_d;
    logic [GRAV_W-1:0] grav_cnt_q, grav_cnt_d;
    logic [3:0]        scan_idx_q, scan_idx_d;
    logic [2:0]        ncleared_q, ncleared_d;

    logic [GRAV_W-1:0] grav_red, grav_diff, grav_period, grav_last;
    logic [3:0]        pts_base;
    logic [7:0]        pts;
    logic [16:0]       score_sum;
    logic [15:0]       score_new;
    logic [8:0]        lines_sum;
    logic [7:0]        lines_new;
    logic [7:0]        lvl_raw;
    logic [3:0]        level_new;

    // Gravity period shrinks with level; clamp before subtracting so it never wraps.
    always_comb begin
        grav_red  = GRAV_W'(level_q) * STEP_W;
        grav_diff = BASE_W - grav_red;
        if (grav_red >= BASE_W || grav_diff < MIN_W) begin
            grav_period = MIN_W;
        end else begin
            grav_period = grav_diff;
        end
        grav_last = grav_period - GRAV_W'(1);
    end

    always_comb begin
        case (ncleared_q)
            3'd0:    pts_base = 4'd0;
            3'd1:    pts_base = 4'd1;
            3'd2:    pts_base = 4'd3;
            3'd3:    pts_base = 4'd5;
            default: pts_base = 4'd8;
        endcase
        pts       = {4'd0, pts_base} * ({4'd0, level_q} + 8'd1);
        score_sum = {1'b0, score_q} + {9'd0, pts};
        score_new = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        lines_sum = {1'b0, lines_q} + {6'd0, ncleared_q};
        lines_new = lines_sum[8] ? 8'hFF : lines_sum[7:0];
        lvl_raw   = lines_new / LPL_W;
        level_new = (lvl_raw > 8'd9) ? 4'd9 : lvl_raw[3:0];
    end

    always_comb begin
        state_d     = state_q;
        drop_tick_d = 1'b0;
        clear_idx_d = clear_idx_q;
        score_d     = score_q;
        lines_d     = lines_q;
        level_d     = level_q;
        grav_cnt_d  = grav_cnt_q;
        scan_idx_d  = scan_idx_q;
        ncleared_d  = ncleared_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    score_d = 16'd0;
                    lines_d = 8'd0;
                    level_d = 4'd0;
                    state_d = GEN;
                end
            end
            GEN: begin
                grav_cnt_d = '0;
                state_d    = PLAY;
            end
            PLAY: begin
                // A landing in the same cycle as the terminal count suppresses the tick.
                if (bottom_flag) begin
                    state_d = top_flag ? OVER : COMMIT;
                end else if (grav_cnt_q == grav_last) begin
                    grav_cnt_d  = '0;
                    drop_tick_d = 1'b1;
                end else begin
                    grav_cnt_d = grav_cnt_q + GRAV_W'(1);
                end
            end
            COMMIT: begin
                scan_idx_d = 4'd0;
                ncleared_d = 3'd0;
                state_d    = SCAN;
            end
            SCAN: begin
                if (row_full[scan_idx_q]) begin
                    clear_idx_d = scan_idx_q;
                    state_d     = CLEAR;
                end else if (scan_idx_q == LAST_ROW) begin
                    state_d = SCORE;
                end else begin
                    scan_idx_d = scan_idx_q + 4'd1;
                end
            end
            CLEAR: begin
                // Rescan the same row: the board shifts the row above into it.
                ncleared_d = (ncleared_q == 3'd4) ? 3'd4 : ncleared_q + 3'd1;
                state_d    = SCAN;
            end
            SCORE: begin
                score_d = score_new;
                lines_d = lines_new;
                level_d = level_new;
                state_d = GEN;
            end
            OVER: begin
                if (Ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        gen_flag_d  = (state_d == GEN);
        commit_d    = (state_d == COMMIT);
        clear_row_d = (state_d == CLEAR);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            gen_flag_q  <= 1'b0;
            drop_tick_q <= 1'b0;
            commit_q    <= 1'b0;
            clear_row_q <= 1'b0;
            game_over_q <= 1'b0;
            clear_idx_q <= 4'd0;
            score_q     <= 16'd0;
            lines_q     <= 8'd0;
            level_q     <= 4'd0;
            grav_cnt_q  <= '0;
            scan_idx_q  <= 4'd0;
            ncleared_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            gen_flag_q  <= gen_flag_d;
            drop_tick_q <= drop_tick_d;
            commit_q    <= commit_d;
            clear_row_q <= clear_row_d;
            game_over_q <= game_over_d;
            clear_idx_q <= clear_idx_d;
            score_q     <= score_d;
            lines_q     <= lines_d;
            level_q     <= level_d;
            grav_cnt_q  <= grav_cnt_d;
            scan_idx_q  <= scan_idx_d;
            ncleared_q  <= ncleared_d;
        end
    end

    assign gen_flag  = gen_flag_q;
    assign drop_tick = drop_tick_q;
    assign commit    = commit_q;
    assign clear_row = clear_row_q;
    assign clear_idx = clear_idx_q;
    assign score     = score_q;
    assign lines     = lines_q;
    assign level     = level_q;
    assign game_over = game_over_q;
    assign state     = state_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl: pulses are predicted into a queue with their
// cycle number and matched as they appear; a small board model answers row_full.
module tb_tetris_game_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Ack = 1'b0;
    logic        bottom_flag = 1'b0;
    logic        top_flag = 1'b0;
    logic [11:0] row_full;
    logic [11:0] board = '0;
    logic [11:0] fill_mask = '0;
    logic        gen_flag, drop_tick, commit, clear_row, game_over;
    logic [3:0]  clear_idx, level;
    logic [15:0] score;
    logic [7:0]  lines, state;

    localparam logic [7:0] S_IDLE = 8'h01, S_GEN = 8'h02, S_PLAY = 8'h04, S_COMMIT = 8'h08;
    localparam logic [7:0] S_OVER = 8'h80;
    localparam int K_GEN = 1, K_DROP = 2, K_COMMIT = 3, K_CLEAR = 4;

    tetris_game_ctrl #(
        .ROWS(12), .GRAV_W(24), .GRAV_BASE(8), .GRAV_STEP(2), .GRAV_MIN(2), .LINES_PER_LVL(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .bottom_flag(bottom_flag), .top_flag(top_flag), .row_full(row_full),
        .gen_flag(gen_flag), .drop_tick(drop_tick), .commit(commit), .clear_row(clear_row),
        .clear_idx(clear_idx), .score(score), .lines(lines), .level(level),
        .game_over(game_over), .state(state)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [11:0] drop_row(input logic [11:0] b, input logic [3:0] k);
        logic [11:0] low;
        low = (12'd1 << k) - 12'd1;
        return (b & low) | ((b >> 1) & ~low);
    endfunction

    always @(posedge Clk) begin
        if (commit) board <= board | fill_mask;
        else if (clear_row) board <= drop_row(board, clear_idx);
    end
    assign row_full = board;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;
    ev_t exp_q[$];

    task automatic push_ev(input int kind, input int c, input int idx);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    always @(negedge Clk) begin
        int np;
        int kind;
        ev_t e;
        np = int'(gen_flag) + int'(drop_tick) + int'(commit) + int'(clear_row);
        if (np != 0) begin
            kind = gen_flag ? K_GEN : drop_tick ? K_DROP : commit ? K_COMMIT : K_CLEAR;
            check("pulse_count", np, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_kind", kind, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", kind, e.kind);
                check("pulse_cycle", cyc, e.cyc);
                if (kind == K_CLEAR) check("clear_idx", clear_idx, e.idx);
            end
        end
    end

    int g;
    int exp_score = 0, exp_lines = 0, exp_level = 0;

    function automatic int period_of(input int lvl);
        int p;
        p = 8 - 2 * lvl;
        return (p < 2) ? 2 : p;
    endfunction

    task automatic wait_until(input int t);
        for (int i = 0; i < 5000 && cyc < t; i++) @(negedge Clk);
        check("wait_reached", cyc >= t, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state, S_IDLE);
        check({tag, "_pulses"}, {gen_flag, drop_tick, commit, clear_row}, 4'b0000);
        check({tag, "_clear_idx"}, clear_idx, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_lines"}, lines, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_game_over"}, game_over, 0);
    endtask

    // One piece: nticks gravity ticks, land `extra` cycles later; rows r..r+n-1 become full.
    task automatic piece(input int nticks, input int extra, input bit top,
                         input int r, input int n, input bit abort);
        int p, land, k;
        int tbl[5] = '{0, 1, 3, 5, 8};
        logic [11:0] m;
        p = period_of(exp_level);
        for (int j = 1; j <= nticks; j++) push_ev(K_DROP, g + 1 + j * p, 0);
        land = g + 1 + nticks * p + extra;
        wait_until(land);
        check("play_state", state, S_PLAY);
        m = '0;
        for (int i = 0; i < 12; i++) m[i] = (i >= r && i < r + n);
        fill_mask   = m;
        bottom_flag = 1'b1;
        top_flag    = top;
        k = land + 1;
        if (!top) begin
            push_ev(K_COMMIT, k, 0);
            for (int j = 0; j < n; j++) push_ev(K_CLEAR, k + 2 + r + 2 * j, r);
            if (!abort) push_ev(K_GEN, k + 2 * n + 14, 0);
        end
        @(negedge Clk);
        bottom_flag = 1'b0;
        top_flag    = 1'b0;
        if (top) begin
            check("over_state", state, S_OVER);
            check("over_flag", game_over, 1);
            return;
        end
        check("commit_state", state, S_COMMIT);
        if (abort) begin
            wait_until(k + 2 + r);
            check("abort_in_clear", clear_row, 1);
            Reset = 1'b1;
            @(negedge Clk);
            Reset = 1'b0;
            check_reset_outputs("mid_clear_reset");
            exp_score = 0;
            exp_lines = 0;
            exp_level = 0;
            return;
        end
        exp_score = exp_score + tbl[n] * (exp_level + 1);
        if (exp_score > 65535) exp_score = 65535;
        exp_lines = exp_lines + n;
        if (exp_lines > 255) exp_lines = 255;
        exp_level = exp_lines / 4;
        if (exp_level > 9) exp_level = 9;
        wait_until(k + 2 * n + 14);
        check("regen_state", state, S_GEN);
        check("score", score, exp_score);
        check("lines", lines, exp_lines);
        check("level", level, exp_level);
        g = cyc;
    endtask

    task automatic start_game();
        Start = 1'b1;
        push_ev(K_GEN, cyc + 1, 0);
        @(negedge Clk);
        Start = 1'b0;
        g = cyc;
        exp_score = 0;
        exp_lines = 0;
        exp_level = 0;
        check("start_state", state, S_GEN);
        check("start_score", score, 0);
        check("start_lines", lines, 0);
        check("start_level", level, 0);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset");
        Reset = 1'b0;

        // Game A: empty landing, two-row clear at the bottom, single clear at row 3, top-out.
        start_game();
        piece(2, 3, 1'b0, 0, 0, 1'b0);
        piece(1, 7, 1'b0, 0, 2, 1'b0);
        piece(0, 1, 1'b0, 3, 1, 1'b0);
        piece(1, 2, 1'b1, 0, 0, 1'b0);

        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("start_ignored_in_over", state, S_OVER);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        check("ack_to_idle", state, S_IDLE);
        check("ack_game_over_low", game_over, 0);
        check("score_retained", score, exp_score);
        check("lines_retained", lines, exp_lines);
        repeat (2) @(negedge Clk);
        check("idle_holds", state, S_IDLE);

        // Game B: two tetrises (level 0 then 1), then reset in the middle of a clear at period 4.
        start_game();
        piece(1, 0, 1'b0, 0, 4, 1'b0);
        piece(1, 5, 1'b0, 0, 4, 1'b0);
        piece(2, 1, 1'b0, 0, 1, 1'b1);

        repeat (3) @(negedge Clk);
        check("final_idle", state, S_IDLE);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
